// File: rtl/alu_pkg.sv
// Shared types for the ALU execution unit: operation codes, FSM states, default width.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_ILL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial datapath shared by unsigned shift-add multiply and restoring divide.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             mode_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] lo_nxt_o,
  output logic [WIDTH-1:0] hi_nxt_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] mq_step;

  assign last_o = (cnt_q == CW'(WIDTH - 1));

  // acc is the product high half (MUL) or partial remainder (DIV); mq is multiplier/quotient.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, m_q} : '0);
    div_shift = {acc_q, mq_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_q};
    div_ge    = ~div_diff[WIDTH];
    if (mode_div_i) begin
      acc_step = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      mq_step  = {mq_q[WIDTH-2:0], div_ge};
    end else begin
      acc_step = mul_sum[WIDTH:1];
      mq_step  = {mul_sum[0], mq_q[WIDTH-1:1]};
    end
  end

  assign lo_nxt_o = mq_step;
  assign hi_nxt_o = acc_step;

  always_comb begin
    acc_d = acc_q;
    mq_d  = mq_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    if (load_i) begin
      acc_d = '0;
      mq_d  = a_i;
      m_d   = b_i;
      cnt_d = '0;
    end else if (step_i) begin
      acc_d = acc_step;
      mq_d  = mq_step;
      cnt_d = last_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      mq_q  <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      mq_q  <= mq_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative unsigned MUL/DIV, start/busy/done handshake.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_control_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             ill_q, ill_d;

  alu_op_e          op;
  logic             upd;
  logic [WIDTH-1:0] res_w, hi_w;
  logic             dbz_w, ill_w;

  logic             iter_load, iter_step, iter_last;
  logic [WIDTH-1:0] iter_lo, iter_hi;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (iter_load),
    .step_i     (iter_step),
    .mode_div_i (state_q == ST_DIV),
    .a_i        (a),
    .b_i        (b),
    .last_o     (iter_last),
    .lo_nxt_o   (iter_lo),
    .hi_nxt_o   (iter_hi)
  );

  always_comb begin
    op        = alu_op_e'(alu_control_in);
    state_d   = state_q;
    iter_load = 1'b0;
    iter_step = 1'b0;
    upd       = 1'b0;
    res_w     = '0;
    hi_w      = '0;
    dbz_w     = 1'b0;
    ill_w     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DONE;
          upd     = 1'b1;
          case (op)
            OP_ADD: res_w = a + b;
            OP_SUB: res_w = a - b;
            OP_AND: res_w = a & b;
            OP_OR:  res_w = a | b;
            OP_XOR: res_w = a ^ b;
            OP_MUL: begin
              upd       = 1'b0;
              iter_load = 1'b1;
              state_d   = ST_MUL;
            end
            OP_DIV: begin
              if (b == '0) begin
                res_w = '1;
                hi_w  = a;
                dbz_w = 1'b1;
              end else begin
                upd       = 1'b0;
                iter_load = 1'b1;
                state_d   = ST_DIV;
              end
            end
            default: ill_w = 1'b1;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        iter_step = 1'b1;
        if (iter_last) begin
          upd     = 1'b1;
          res_w   = iter_lo;
          hi_w    = iter_hi;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs change only on entry to DONE, so they hold until the next done pulse.
  always_comb begin
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    ill_d    = ill_q;
    if (upd) begin
      result_d = res_w;
      hi_d     = hi_w;
      zero_d   = (res_w == '0);
      dbz_d    = dbz_w;
      ill_d    = ill_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign result      = result_q;
  assign hi          = hi_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   alu_control_in;
  logic [W-1:0] a, b;
  logic         busy, done, zero, div_by_zero, illegal_op;
  logic [W-1:0] result, hi;

  int nvec = 0;
  int nerr = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .alu_control_in (alu_control_in),
    .a              (a),
    .b              (b),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .hi             (hi),
    .zero           (zero),
    .div_by_zero    (div_by_zero),
    .illegal_op     (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one op, scrambles inputs after acceptance, watches a fixed window of cycles.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [W-1:0] av, input logic [W-1:0] bv, input int inj_at,
                        input int exp_lat, input logic [W-1:0] exp_res, input logic [W-1:0] exp_hi,
                        input logic exp_z, input logic exp_dbz, input logic exp_ill);
    int first;
    int nd;
    logic [W-1:0] r_c, h_c;
    logic z_c, d_c, i_c;
    first = -1;
    nd = 0;
    r_c = 'x; h_c = 'x; z_c = 1'bx; d_c = 1'bx; i_c = 1'bx;
    @(negedge clk);
    start = 1'b1; alu_control_in = op; a = av; b = bv;
    @(posedge clk);
    #1;
    start = 1'b0; alu_control_in = 3'b001; a = ~av; b = 32'h3;
    for (int c = 1; c <= int'(W) + 4; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (first < 0) begin
          first = c;
          r_c = result; h_c = hi; z_c = zero; d_c = div_by_zero; i_c = illegal_op;
        end
      end
      if (c == inj_at) begin
        start = 1'b1; alu_control_in = 3'b001; a = 32'h9; b = 32'h4;
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, ".latency"}, 64'(first), 64'(exp_lat));
    chk({tag, ".ndone"}, 64'(nd), 64'd1);
    chk({tag, ".result"}, 64'(r_c), 64'(exp_res));
    chk({tag, ".hi"}, 64'(h_c), 64'(exp_hi));
    chk({tag, ".zero"}, 64'(z_c), 64'(exp_z));
    chk({tag, ".div_by_zero"}, 64'(d_c), 64'(exp_dbz));
    chk({tag, ".illegal_op"}, 64'(i_c), 64'(exp_ill));
    chk({tag, ".result_hold"}, 64'(result), 64'(exp_res));
    chk({tag, ".hi_hold"}, 64'(hi), 64'(exp_hi));
    chk({tag, ".busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int nd;
    rst_n = 1'b0; start = 1'b0; alu_control_in = 3'b000; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.result", 64'(result), 64'd0);
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.flags", 64'({zero, div_by_zero, illegal_op}), 64'd0);
    rst_n = 1'b1;

    run_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h1, 0, 1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    run_op("sub_wrap", 3'b001, 32'h5, 32'h7, 0, 1, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 1'b0);
    run_op("and", 3'b100, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1, 32'h00F0_1200, 32'h0, 1'b0, 1'b0, 1'b0);
    run_op("or", 3'b101, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1, 32'hFFF0_FF34, 32'h0, 1'b0, 1'b0, 1'b0);
    run_op("mul_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 33, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("mul_hi_only", 3'b010, 32'h0001_0000, 32'h0001_0000, 0, 33, 32'h0, 32'h1, 1'b1, 1'b0, 1'b0);
    run_op("div_100_7", 3'b011, 32'd100, 32'd7, 0, 33, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
    run_op("div_by_zero", 3'b011, 32'd5, 32'd0, 0, 1, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1, 1'b0);
    run_op("div_small", 3'b011, 32'd3, 32'd10, 0, 33, 32'd0, 32'd3, 1'b1, 1'b0, 1'b0);
    run_op("illegal", 3'b111, 32'd1, 32'd2, 0, 1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    run_op("mul_ignore_start", 3'b010, 32'd3, 32'd5, 5, 33, 32'd15, 32'd0, 1'b0, 1'b0, 1'b0);

    // Abort a DIV with reset at cycle 10.
    @(negedge clk);
    start = 1'b1; alu_control_in = 3'b011; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort.busy_before", 64'(busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk("abort.result", 64'(result), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < int'(W) + 4; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort.no_done", 64'(nd), 64'd0);
    run_op("xor_after_reset", 3'b110, 32'hF0, 32'hFF, 0, 1, 32'h0F, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
